// File: rtl/dff_pipe_chain_pkg.sv
// Shared constants and helpers for the dff_pipe_chain register chain.
// Optional feature macro: DFF_PIPE_FLUSH_EN (adds the flush input).
package dff_pipe_chain_pkg;

    localparam int DFF_PIPE_DEF_WIDTH = 4;
    localparam int DFF_PIPE_DEF_DEPTH = 3;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_chain_if.sv
// Handshake bundle for dff_pipe_chain: input side, output side and occupancy.
// With DFF_PIPE_FLUSH_EN defined the bundle also carries flush.
interface dff_pipe_chain_if
    import dff_pipe_chain_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_DEF_WIDTH,
    parameter int DEPTH = DFF_PIPE_DEF_DEPTH
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [WIDTH-1:0]              out_data;
    logic [count_width(DEPTH)-1:0] count;
`ifdef DFF_PIPE_FLUSH_EN
    logic                          flush;

    modport master (output in_valid, in_data, out_ready, flush,
                    input  in_ready, out_valid, out_data, count);
    modport slave  (input  in_valid, in_data, out_ready, flush,
                    output in_ready, out_valid, out_data, count);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, count);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, count);
`endif

endinterface

// File: rtl/dff_pipe_chain_pipe_stage.sv
// One valid/data register pair of the chain. rst clears both, clr clears
// only the valid bit, and data loads only when the incoming word is valid.
module pipe_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (clr) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= src_valid;
            if (src_valid) begin
                data_reg <= src_data;
            end
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/dff_pipe_chain.sv
// DEPTH-stage handshaked register chain with bubble collapse and a
// combinational ready path. Optional flush via DFF_PIPE_FLUSH_EN.
module dff_pipe_chain
    import dff_pipe_chain_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_DEF_WIDTH,
    parameter int DEPTH = DFF_PIPE_DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    dff_pipe_chain_if.slave  bus
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] space;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             flush_now;
    logic             in_ready_int;
    logic             accept;
    logic             pop;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

`ifdef DFF_PIPE_FLUSH_EN
    assign flush_now = bus.flush;
`else
    assign flush_now = 1'b0;
`endif

    // Walk from the output end back: a stage has room if it is empty or
    // its word is leaving; "ahead" carries the room of the next stage.
    always_comb begin
        logic ahead;
        space = '0;
        adv   = '0;
        ahead = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i]   = v[i] & ahead;
            space[i] = ~v[i] | adv[i];
            ahead    = space[i];
        end
    end

    assign in_ready_int = space[0] & ~flush_now;
    assign accept       = bus.in_valid & in_ready_int;
    assign pop          = v[DEPTH-1] & bus.out_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign src_v[gi] = bus.in_valid;
            assign src_d[gi] = bus.in_data;
        end else begin : g_body
            assign src_v[gi] = v[gi-1];
            assign src_d[gi] = d[gi-1];
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clr       (flush_now),
            .load      (space[gi]),
            .src_valid (src_v[gi]),
            .src_data  (src_d[gi]),
            .valid     (v[gi]),
            .data      (d[gi])
        );
    end

    always_comb begin
        count_next = count_reg;
        case ({accept, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_now) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Outputs are forced to their idle values for as long as rst is held.
    assign bus.in_ready  = rst | in_ready_int;
    assign bus.out_valid = ~rst & v[DEPTH-1];
    assign bus.out_data  = rst ? '0 : d[DEPTH-1];
    assign bus.count     = rst ? '0 : count_reg;

endmodule

// File: tb/tb_dff_pipe_chain.sv
// Self-checking bench for dff_pipe_chain (WIDTH=4, DEPTH=3): directed steps
// then random traffic, against a word/position reference model.
module tb_dff_pipe_chain;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dff_pipe_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dff_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: words in flight (oldest first) with their stage index.
    logic [WIDTH-1:0] mw[$];
    int               mp[$];
    int               np[$];
    logic [WIDTH-1:0] last_out = '0;
    logic             e_ir, e_ov;
    logic [WIDTH-1:0] e_od;
    int               e_cnt;
    bit               dut_acc;
    logic [WIDTH-1:0] got[$];

    function automatic bit cur_flush();
`ifdef DFF_PIPE_FLUSH_EN
        return bus.flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // A word moves one stage forward unless the word ahead ends up adjacent.
    task automatic model_comb();
        int prev;
        np.delete();
        prev  = DEPTH;
        e_ov  = (mw.size() > 0) && (mp[0] == DEPTH - 1);
        for (int k = 0; k < mw.size(); k++) begin
            int p;
            if (k == 0 && e_ov && bus.out_ready) p = DEPTH;
            else begin
                p = mp[k] + 1;
                if (p > prev - 1) p = prev - 1;
                if (p > DEPTH - 1) p = DEPTH - 1;
            end
            np.push_back(p);
            prev = p;
        end
        e_ir  = (prev >= 1) && !cur_flush();
        e_od  = e_ov ? mw[0] : last_out;
        e_cnt = mw.size();
        if (rst) begin
            e_ir = 1'b1; e_ov = 1'b0; e_od = '0; e_cnt = 0;
        end
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] nw[$];
        int               npos[$];
        if (rst) begin
            mw.delete(); mp.delete(); last_out = '0;
        end else if (cur_flush()) begin
            mw.delete(); mp.delete();
        end else begin
            for (int k = 0; k < mw.size(); k++) begin
                if (np[k] < DEPTH) begin
                    nw.push_back(mw[k]);
                    npos.push_back(np[k]);
                end
            end
            if (bus.in_valid && e_ir) begin
                nw.push_back(bus.in_data);
                npos.push_back(0);
            end
            mw = nw;
            mp = npos;
            for (int k = 0; k < mw.size(); k++)
                if (mp[k] == DEPTH - 1) last_out = mw[k];
        end
    endtask

    // Inputs change just after posedge; outputs are checked at negedge.
    task automatic cycle();
        @(negedge clk);
        model_comb();
        check("in_ready",  {31'd0, bus.in_ready},  {31'd0, e_ir});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, e_ov});
        check("out_data",  {28'd0, bus.out_data},  {28'd0, e_od});
        check("count",     {30'd0, bus.count},     e_cnt);
        dut_acc = !rst && bus.in_valid && bus.in_ready;
        if (!rst && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
    endtask

    initial begin
        logic [WIDTH-1:0] words [5];
        int               idx;
        int               budget;

`ifdef DFF_PIPE_FLUSH_EN
        bus.flush = 1'b0;
`endif
        // 1. Reset with a word offered: nothing may be accepted.
        rst = 1'b1;
        drive(1'b1, 4'hF, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b0);
        cycle();

        // 2. Streaming 1..4 with the sink always ready.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, WIDTH'(i), 1'b1);
            cycle();
        end
        drive(1'b0, 4'h0, 1'b1);
        repeat (4) cycle();

        // 3. Backpressure: the source holds a word until it is accepted.
        words = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        got.delete();
        idx = 0;
        repeat (5) begin
            drive(1'b1, words[idx], 1'b0);
            cycle();
            if (dut_acc) idx++;
        end
        check("bp_accepted", idx, 3);
        budget = 20;
        while (idx < 5 && budget > 0) begin
            drive(1'b1, words[idx], 1'b1);
            cycle();
            if (dut_acc) idx++;
            budget--;
        end
        check("bp_budget", {31'd0, budget > 0}, 1);
        drive(1'b0, 4'h0, 1'b1);
        repeat (5) cycle();
        check("bp_delivered", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            check("bp_order", {28'd0, got[i]}, {28'd0, words[i]});

        // 4. Bubble collapse, fill to full, then simultaneous push and pop.
        drive(1'b1, 4'h7, 1'b0); cycle();
        drive(1'b0, 4'h0, 1'b0); cycle(); cycle();
        drive(1'b1, 4'h8, 1'b0); cycle();
        drive(1'b1, 4'h5, 1'b0); cycle();
        drive(1'b1, 4'h6, 1'b1); cycle();
        drive(1'b0, 4'h0, 1'b0); cycle();
        check("t4_full_count", {30'd0, bus.count}, 3);
        drive(1'b0, 4'h0, 1'b1);
        repeat (4) cycle();

        // 5. Reset while full, then a fresh word.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, WIDTH'(i + 10), 1'b0);
            cycle();
        end
        rst = 1'b1;
        drive(1'b1, 4'h3, 1'b1);
        cycle();
        rst = 1'b0;
        drive(1'b1, 4'h9, 1'b1); cycle();
        drive(1'b0, 4'h0, 1'b1);
        repeat (4) cycle();

`ifdef DFF_PIPE_FLUSH_EN
        // 6. Flush a full chain while a word is offered.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, WIDTH'(i), 1'b0);
            cycle();
        end
        bus.flush = 1'b1;
        drive(1'b1, 4'hC, 1'b0);
        cycle();
        bus.flush = 1'b0;
        drive(1'b0, 4'h0, 1'b1);
        repeat (3) cycle();
`endif

        // Random traffic with occasional resets.
        repeat (400) begin
            rst = ($urandom_range(0, 99) == 0);
`ifdef DFF_PIPE_FLUSH_EN
            bus.flush = ($urandom_range(0, 19) == 0);
`endif
            drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 3) != 0));
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
